// File: rtl/traffic_light_ctrl.sv
// Four-way intersection controller: parametrised green/yellow/left/all-red sequencing,
// pedestrian early green exit and flashing-yellow maintenance mode; all outputs registered.
module traffic_light_ctrl #(
  parameter int TW         = 8,
  parameter int G_TIME     = 40,
  parameter int Y_TIME     = 5,
  parameter int LT_TIME    = 20,
  parameter int AR_TIME    = 2,
  parameter int MIN_GREEN  = 10,
  parameter int FLASH_HALF = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flash_en,
  input  logic          ped_req,
  output logic          ns_g,
  output logic          ns_y,
  output logic          ns_r,
  output logic          ns_lt,
  output logic          ew_g,
  output logic          ew_y,
  output logic          ew_r,
  output logic          ew_lt,
  output logic [3:0]    phase,
  output logic [TW-1:0] timer,
  output logic          ped_ack
);

  typedef enum logic [3:0] {
    ALL_RED = 4'd0,
    NS_G    = 4'd1,
    NS_Y    = 4'd2,
    EW_LT   = 4'd3,
    EW_LT_Y = 4'd4,
    EW_G    = 4'd5,
    EW_Y    = 4'd6,
    NS_LT   = 4'd7,
    NS_LT_Y = 4'd8,
    FLASH   = 4'd9
  } phase_e;

  localparam logic [TW-1:0] G_LAST  = TW'(G_TIME - 1);
  localparam logic [TW-1:0] Y_LAST  = TW'(Y_TIME - 1);
  localparam logic [TW-1:0] LT_LAST = TW'(LT_TIME - 1);
  localparam logic [TW-1:0] AR_LAST = TW'(AR_TIME - 1);
  localparam logic [TW-1:0] MG_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] FH_LAST = TW'(FLASH_HALF - 1);

  phase_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pend_q, pend_d;
  logic          ack_q, ack_d;
  logic          blink_q, blink_d;
  // {ns_g, ns_y, ns_r, ns_lt, ew_g, ew_y, ew_r, ew_lt}
  logic [7:0]    lamps_q, lamps_d;
  logic [TW-1:0] last;
  logic          is_green, early, expire;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + TW'(1);
    pend_d   = pend_q | ped_req;
    ack_d    = 1'b0;
    blink_d  = blink_q;
    lamps_d  = 8'b0010_0010;
    last     = '0;
    is_green = (state_q == NS_G) || (state_q == EW_G);

    case (state_q)
      ALL_RED:                         last = AR_LAST;
      NS_G, EW_G:                      last = G_LAST;
      NS_Y, EW_LT_Y, EW_Y, NS_LT_Y:    last = Y_LAST;
      EW_LT, NS_LT:                    last = LT_LAST;
      FLASH:                           last = FH_LAST;
      default:                         last = '0;
    endcase

    early  = is_green && pend_q && (timer_q >= MG_LAST);
    expire = (timer_q == last);

    if (flash_en) begin
      if (state_q != FLASH) begin
        state_d = FLASH;
        timer_d = '0;
        blink_d = 1'b1;
      end else if (expire) begin
        timer_d = '0;
        blink_d = ~blink_q;
      end
    end else if (state_q == FLASH) begin
      state_d = ALL_RED;
      timer_d = '0;
    end else if (4'(state_q) > 4'd9) begin
      state_d = ALL_RED;
      timer_d = '0;
    end else if (early || expire) begin
      timer_d = '0;
      ack_d   = early;
      // a request landing on the clearing edge survives
      if (is_green) pend_d = ped_req;
      case (state_q)
        ALL_RED: state_d = NS_G;
        NS_G:    state_d = NS_Y;
        NS_Y:    state_d = EW_LT;
        EW_LT:   state_d = EW_LT_Y;
        EW_LT_Y: state_d = EW_G;
        EW_G:    state_d = EW_Y;
        EW_Y:    state_d = NS_LT;
        NS_LT:   state_d = NS_LT_Y;
        NS_LT_Y: state_d = NS_G;
        default: state_d = ALL_RED;
      endcase
    end

    case (state_d)
      NS_G:    lamps_d = 8'b1000_0010;
      NS_Y:    lamps_d = 8'b0100_0010;
      EW_LT:   lamps_d = 8'b0010_0011;
      EW_LT_Y: lamps_d = 8'b0010_0100;
      EW_G:    lamps_d = 8'b0010_1000;
      EW_Y:    lamps_d = 8'b0010_0100;
      NS_LT:   lamps_d = 8'b0011_0010;
      NS_LT_Y: lamps_d = 8'b0100_0010;
      FLASH:   lamps_d = {1'b0, blink_d, 2'b00, 1'b0, blink_d, 2'b00};
      default: lamps_d = 8'b0010_0010;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALL_RED;
      timer_q <= '0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      blink_q <= 1'b0;
      lamps_q <= 8'b0010_0010;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      blink_q <= blink_d;
      lamps_q <= lamps_d;
    end
  end

  assign {ns_g, ns_y, ns_r, ns_lt, ew_g, ew_y, ew_r, ew_lt} = lamps_q;
  assign phase   = 4'(state_q);
  assign timer   = timer_q;
  assign ped_ack = ack_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed scenarios plus random stimulus against a
// behavioural model of phase durations, pedestrian pending and flash blinking.
module tb_traffic_light_ctrl;
  localparam int G = 40, Y = 5, LT = 20, AR = 2, MG = 10, FH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flash_en, ped_req;
  logic ns_g, ns_y, ns_r, ns_lt, ew_g, ew_y, ew_r, ew_lt, ped_ack;
  logic [3:0] phase;
  logic [7:0] timer;

  traffic_light_ctrl #(.TW(8), .G_TIME(G), .Y_TIME(Y), .LT_TIME(LT), .AR_TIME(AR),
                       .MIN_GREEN(MG), .FLASH_HALF(FH)) dut (
    .clk(clk), .rst(rst), .flash_en(flash_en), .ped_req(ped_req),
    .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r), .ns_lt(ns_lt),
    .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r), .ew_lt(ew_lt),
    .phase(phase), .timer(timer), .ped_ack(ped_ack)
  );

  // minimal-timing instance: every phase lasts one cycle
  logic s_rst, s_flash, s_ped;
  logic s_ns_g, s_ns_y, s_ns_r, s_ns_lt, s_ew_g, s_ew_y, s_ew_r, s_ew_lt, s_ack;
  logic [3:0] s_phase;
  logic [7:0] s_timer;

  traffic_light_ctrl #(.TW(8), .G_TIME(1), .Y_TIME(1), .LT_TIME(1), .AR_TIME(1),
                       .MIN_GREEN(1), .FLASH_HALF(1)) dut_min (
    .clk(clk), .rst(s_rst), .flash_en(s_flash), .ped_req(s_ped),
    .ns_g(s_ns_g), .ns_y(s_ns_y), .ns_r(s_ns_r), .ns_lt(s_ns_lt),
    .ew_g(s_ew_g), .ew_y(s_ew_y), .ew_r(s_ew_r), .ew_lt(s_ew_lt),
    .phase(s_phase), .timer(s_timer), .ped_ack(s_ack)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ph = 0, m_el = 0;
  bit m_pend = 0, m_ack = 0, m_blink = 0;

  function automatic int dur(input int ph);
    if (ph == 0) return AR;
    if (ph == 1 || ph == 5) return G;
    if (ph == 3 || ph == 7) return LT;
    return Y;
  endfunction

  function automatic int succ(input int ph);
    return (ph == 0 || ph == 8) ? 1 : ph + 1;
  endfunction

  // {ns_g, ns_y, ns_r, ns_lt, ew_g, ew_y, ew_r, ew_lt}
  function automatic logic [7:0] lamp_vec(input int ph, input bit b);
    case (ph)
      1: return 8'b1000_0010;
      2: return 8'b0100_0010;
      3: return 8'b0010_0011;
      4: return 8'b0010_0100;
      5: return 8'b0010_1000;
      6: return 8'b0010_0100;
      7: return 8'b0011_0010;
      8: return 8'b0100_0010;
      9: return {1'b0, b, 2'b00, 1'b0, b, 2'b00};
      default: return 8'b0010_0010;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit f, input bit p);
    bit green, early;
    m_ack = 0;
    if (r) begin
      m_ph = 0; m_el = 0; m_pend = 0; m_blink = 0;
    end else if (f) begin
      if (m_ph != 9) begin
        m_ph = 9; m_el = 0; m_blink = 1;
      end else begin
        m_el++;
        if (m_el == FH) begin m_el = 0; m_blink = !m_blink; end
      end
      if (p) m_pend = 1;
    end else if (m_ph == 9) begin
      m_ph = 0; m_el = 0;
      if (p) m_pend = 1;
    end else begin
      green = (m_ph == 1 || m_ph == 5);
      early = green && m_pend && (m_el + 1 >= MG);
      if (early || m_el + 1 == dur(m_ph)) begin
        if (green) m_pend = 0;
        m_ack = early;
        m_ph  = succ(m_ph);
        m_el  = 0;
      end else begin
        m_el++;
      end
      if (p) m_pend = 1;
    end
  endtask

  task automatic cycle(input bit r, input bit f, input bit p);
    rst = r; flash_en = f; ped_req = p;
    model_step(r, f, p);
    @(negedge clk);
    check("phase", 32'(phase), 32'(m_ph));
    check("timer", 32'(timer), 32'(m_el));
    check("lamps", {ns_g, ns_y, ns_r, ns_lt, ew_g, ew_y, ew_r, ew_lt}, lamp_vec(m_ph, m_blink));
    check("ped_ack", 32'(ped_ack), 32'(m_ack));
  endtask

  initial begin
    int first_g, second_g, ack_cnt, last_g_t, ny_start, elt_start, ack_at;
    int prev_ph, run_len, g_len, exp_len;
    bit found, first_run, seen;
    int flash_left;

    rst = 1; flash_en = 0; ped_req = 0;
    s_rst = 1; s_flash = 0; s_ped = 0;

    // reset and free-run the default sequence
    cycle(1, 0, 0);
    check("reset_phase", 32'(phase), 32'd0);
    check("reset_lamps", {ns_g, ns_y, ns_r, ns_lt, ew_g, ew_y, ew_r, ew_lt}, 32'h22);
    first_g = -1; second_g = -1;
    for (int k = 1; k <= 300; k++) begin
      cycle(0, 0, 0);
      if (phase == 4'd1 && timer == 8'd0) begin
        if (first_g < 0) first_g = k;
        else if (second_g < 0) second_g = k;
      end
    end
    check("ns_g_first_start", first_g, 2);
    check("ns_g_second_start", second_g, 142);

    // pedestrian pulse at NS_G timer=3
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (phase == 4'd1 && timer == 8'd3) found = 1;
      else cycle(0, 0, 0);
    end
    check("wait_nsg_t3", found, 1);
    ack_cnt = 0; last_g_t = -1; ny_start = -1; elt_start = -1; ack_at = -1;
    for (int k = 0; k < 40; k++) begin
      cycle(0, 0, k == 0);
      if (ped_ack) begin ack_cnt++; ack_at = k; end
      if (phase == 4'd1 && ny_start < 0) last_g_t = timer;
      if (phase == 4'd2 && timer == 8'd0) ny_start = k;
      if (phase == 4'd3 && timer == 8'd0) elt_start = k;
    end
    check("ped_last_green_timer", last_g_t, 9);
    check("ped_ack_count", ack_cnt, 1);
    check("ped_ack_at_yellow", ack_at, ny_start);
    check("ped_ew_lt_after_y", elt_start - ny_start, 5);

    // ped_req held high: greens shortened to MIN_GREEN
    prev_ph = phase; run_len = 1; first_run = 1;
    for (int k = 0; k < 300; k++) begin
      cycle(0, 0, 1);
      if (phase == prev_ph[3:0]) run_len++;
      else begin
        if (!first_run) begin
          exp_len = (prev_ph == 1 || prev_ph == 5) ? 10 :
                    (prev_ph == 3 || prev_ph == 7) ? 20 : 5;
          check("held_ped_run_len", run_len, exp_len);
        end
        first_run = 0; prev_ph = phase; run_len = 1;
      end
    end

    // flash entry mid EW_G, blink pattern, exit through ALL_RED
    cycle(1, 0, 0);
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (phase == 4'd5 && timer == 8'd17) found = 1;
      else cycle(0, 0, 0);
    end
    check("wait_ewg_t17", found, 1);
    for (int k = 0; k < 24; k++) begin
      cycle(0, 1, 0);
      check("flash_phase", 32'(phase), 32'd9);
      check("flash_blink", {ns_y, ew_y, ns_g, ns_r, ew_g, ew_r, ns_lt, ew_lt},
            ((k / 8) % 2 == 0) ? 32'hC0 : 32'h00);
    end
    cycle(0, 0, 0); check("flash_exit_0", 32'(phase), 32'd0);
    cycle(0, 0, 0); check("flash_exit_1", 32'(phase), 32'd0);
    cycle(0, 0, 0); check("flash_exit_2", 32'(phase), 32'd1);

    // reset during NS_LT timer=12 with a pending request
    found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      if (phase == 4'd7 && timer == 8'd12) found = 1;
      else cycle(0, 0, phase == 4'd7);
    end
    check("wait_nslt_t12", found, 1);
    cycle(1, 0, 0);
    check("mid_reset_phase", 32'(phase), 32'd0);
    check("mid_reset_timer", 32'(timer), 32'd0);
    check("mid_reset_lamps", {ns_g, ns_y, ns_r, ns_lt, ew_g, ew_y, ew_r, ew_lt}, 32'h22);
    g_len = 0; seen = 0;
    for (int k = 0; k < 100; k++) begin
      cycle(0, 0, 0);
      if (phase == 4'd1) begin g_len++; seen = 1; end
    end
    check("post_reset_green_len", g_len, 40);

    // random stimulus against the model
    flash_left = 0;
    for (int k = 0; k < 3000; k++) begin
      if (flash_left == 0 && $urandom_range(0, 299) == 0) flash_left = $urandom_range(1, 40);
      cycle($urandom_range(0, 499) == 0, flash_left > 0, $urandom_range(0, 29) == 0);
      if (flash_left > 0) flash_left--;
    end

    // minimal-timing instance: one cycle per phase, cycle length 8
    s_rst = 1; s_ped = 0;
    @(negedge clk);
    check("min_reset_phase", 32'(s_phase), 32'd0);
    s_rst = 0;
    for (int k = 1; k <= 33; k++) begin
      s_ped = (k > 16);
      @(negedge clk);
      check("min_phase", 32'(s_phase), 32'(((k - 1) % 8) + 1));
      check("min_timer", 32'(s_timer), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
